// File: rtl/parser_pkg.sv
// Shared constants and tag type for the parser ingress arbiter slice.
package parser_pkg;

    localparam int DATA_WIDTH = 480;
    localparam int QID_WIDTH  = 3;
    localparam int PARSER_LAT = 3;

    typedef struct packed {
        logic                 v;
        logic [QID_WIDTH-1:0] qid;
    } tag_t;

    // Successor of a queue index with an explicit wrap, so non power-of-2 queue counts work.
    function automatic logic [QID_WIDTH-1:0] next_ptr(input logic [QID_WIDTH-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/parser_ingress_arbiter_if.sv
// Ingress handshake, parser issue/return and status signals of the ingress arbiter.
interface parser_ingress_arbiter_if
    import parser_pkg::*;
#(
    parameter int NUM_QUEUES = 8,
    parameter int CNT_WIDTH  = 16
) ();

    logic [NUM_QUEUES-1:0]            in_vld;
    logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_QUEUES-1:0]            in_rdy;
    logic [NUM_QUEUES-1:0]            cfg_port_en;
    logic                             prs_vld;
    logic [DATA_WIDTH-1:0]            prs_data;
    logic                             prs_vld_out;
    logic                             tag_vld;
    logic [QID_WIDTH-1:0]             tag_qid;
    logic                             drop_pulse;
    logic [QID_WIDTH-1:0]             drop_qid;
    logic [CNT_WIDTH-1:0]             drop_cnt;
    logic                             err_orphan;

    // Arbiter side: owns the ready lines, the parser issue port and all status.
    modport master (
        input  in_vld, in_data, cfg_port_en, prs_vld_out,
        output in_rdy, prs_vld, prs_data, tag_vld, tag_qid,
        output drop_pulse, drop_qid, drop_cnt, err_orphan
    );

    // Environment side: ingress queues, parser result valid and status consumers.
    modport slave (
        output in_vld, in_data, cfg_port_en, prs_vld_out,
        input  in_rdy, prs_vld, prs_data, tag_vld, tag_qid,
        input  drop_pulse, drop_qid, drop_cnt, err_orphan
    );

endinterface

// File: rtl/parser_ingress_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at NUM_QUEUES.
module rr_arbiter
    import parser_pkg::*;
#(
    parameter int NUM_QUEUES = 8
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [QID_WIDTH-1:0]  ptr,
    output logic [NUM_QUEUES-1:0] grant,
    output logic [QID_WIDTH-1:0]  grant_idx,
    output logic                  grant_vld
);

    localparam int SW = QID_WIDTH + 1;

    logic [QID_WIDTH-1:0]  rot_idx [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] rot_req;

    // rot_idx[k] is the queue examined at search distance k from ptr.
    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_rot
        logic [SW-1:0] sum;
        assign sum         = {1'b0, ptr} + SW'(gi);
        assign rot_idx[gi] = (sum >= SW'(NUM_QUEUES)) ? QID_WIDTH'(sum - SW'(NUM_QUEUES))
                                                      : sum[QID_WIDTH-1:0];
        assign rot_req[gi] = req[rot_idx[gi]];
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                grant_idx = rot_idx[k];
                grant_vld = 1'b1;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/parser_ingress_arbiter.sv
// Shares one fixed-latency header parser among NUM_QUEUES ingress queues and re-tags
// parser results with their source queue, counting headers the parser rejects.
module parser_ingress_arbiter
    import parser_pkg::*;
#(
    parameter int NUM_QUEUES = 8,
    parameter int CNT_WIDTH  = 16
) (
    input logic                     clk,
    input logic                     reset,
    parser_ingress_arbiter_if.master bus
);

    logic [NUM_QUEUES-1:0] eligible;
    logic [NUM_QUEUES-1:0] grant;
    logic [QID_WIDTH-1:0]  grant_idx;
    logic                  grant_vld;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] q_data [NUM_QUEUES];
    logic [DATA_WIDTH-1:0] sel_data;

    logic [QID_WIDTH-1:0]  ptr_reg, ptr_next;
    logic                  prs_vld_reg;
    logic [DATA_WIDTH-1:0] prs_data_reg;
    logic [QID_WIDTH-1:0]  issue_qid_reg;
    tag_t                  tag_pipe_reg [PARSER_LAT];
    tag_t                  tail;

    logic                  tag_vld_reg;
    logic [QID_WIDTH-1:0]  tag_qid_reg;
    logic                  drop_pulse_reg;
    logic [QID_WIDTH-1:0]  drop_qid_reg;
    logic [CNT_WIDTH-1:0]  drop_cnt_reg, drop_cnt_next;
    logic                  err_orphan_reg;
    logic                  hit, miss, orphan;

    assign eligible = bus.in_vld & bus.cfg_port_en;

    rr_arbiter #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Ready is held low for the whole reset window, not just until the next edge.
    assign bus.in_rdy = reset ? '0 : grant;
    assign xfer       = grant_vld & ~reset;

    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_split
        assign q_data[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    assign sel_data = q_data[grant_idx];

    always_comb begin
        ptr_next = ptr_reg;
        if (xfer) begin
            ptr_next = next_ptr(grant_idx, NUM_QUEUES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg       <= '0;
            prs_vld_reg   <= 1'b0;
            prs_data_reg  <= '0;
            issue_qid_reg <= '0;
        end else begin
            ptr_reg     <= ptr_next;
            prs_vld_reg <= xfer;
            if (xfer) begin
                prs_data_reg  <= sel_data;
                issue_qid_reg <= grant_idx;
            end
        end
    end

    // Stage 0 captures the header issued this cycle, so the tail lines up with prs_vld_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < PARSER_LAT; s++) begin
                tag_pipe_reg[s] <= '0;
            end
        end else begin
            tag_pipe_reg[0] <= '{v: prs_vld_reg, qid: issue_qid_reg};
            for (int s = 1; s < PARSER_LAT; s++) begin
                tag_pipe_reg[s] <= tag_pipe_reg[s-1];
            end
        end
    end

    assign tail   = tag_pipe_reg[PARSER_LAT-1];
    assign hit    = tail.v & bus.prs_vld_out;
    assign miss   = tail.v & ~bus.prs_vld_out;
    assign orphan = ~tail.v & bus.prs_vld_out;

    assign drop_cnt_next = (drop_cnt_reg == '1) ? drop_cnt_reg : drop_cnt_reg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_reg    <= 1'b0;
            tag_qid_reg    <= '0;
            drop_pulse_reg <= 1'b0;
            drop_qid_reg   <= '0;
            drop_cnt_reg   <= '0;
            err_orphan_reg <= 1'b0;
        end else begin
            tag_vld_reg    <= hit;
            drop_pulse_reg <= miss;
            if (hit) begin
                tag_qid_reg <= tail.qid;
            end
            if (miss) begin
                drop_qid_reg <= tail.qid;
                drop_cnt_reg <= drop_cnt_next;
            end
            if (orphan) begin
                err_orphan_reg <= 1'b1;
            end
        end
    end

    assign bus.prs_vld    = prs_vld_reg;
    assign bus.prs_data   = prs_data_reg;
    assign bus.tag_vld    = tag_vld_reg;
    assign bus.tag_qid    = tag_qid_reg;
    assign bus.drop_pulse = drop_pulse_reg;
    assign bus.drop_qid   = drop_qid_reg;
    assign bus.drop_cnt   = drop_cnt_reg;
    assign bus.err_orphan = err_orphan_reg;

endmodule

// File: tb/tb_parser_ingress_arbiter.sv
// Directed bench for parser_ingress_arbiter; a 2-bit-counter twin checks drop_cnt saturation.
module tb_parser_ingress_arbiter;
    import parser_pkg::*;

    localparam int NQ = 8;
    localparam int DW = DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inject = 1'b0;
    logic [2:0] pv;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parser_ingress_arbiter_if #(.NUM_QUEUES(NQ), .CNT_WIDTH(16)) bus ();
    parser_ingress_arbiter_if #(.NUM_QUEUES(NQ), .CNT_WIDTH(2))  bus_s ();

    parser_ingress_arbiter #(.NUM_QUEUES(NQ), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    parser_ingress_arbiter #(.NUM_QUEUES(NQ), .CNT_WIDTH(2)) dut_s (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_s)
    );

    assign bus_s.in_vld      = bus.in_vld;
    assign bus_s.in_data     = bus.in_data;
    assign bus_s.cfg_port_en = bus.cfg_port_en;
    assign bus_s.prs_vld_out = bus.prs_vld_out;

    function automatic logic [DW-1:0] mk_hdr(input int q, input logic [15:0] et, input logic [7:0] pr);
        logic [DW-1:0] h;
        h            = '0;
        h[479:448]   = 32'hA5A5_0000 + 32'(q);
        h[383:368]   = et;
        h[295:288]   = pr;
        h[31:0]      = 32'hC0DE_0000 | 32'(q);
        return h;
    endfunction

    function automatic logic good_hdr(input logic [DW-1:0] h);
        return (h[383:368] == 16'h0800) && (h[295:288] == 8'h06);
    endfunction

    // Parser stand-in: valid three cycles after input, only for IPv4/TCP headers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pv <= '0;
        else     pv <= {pv[1:0], bus.prs_vld & good_hdr(bus.prs_data)};
    end
    assign bus.prs_vld_out = pv[2] | inject;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        if (obs === exp) $display("vec %0d %s = 0x%0h ok", n_vec, tag, obs);
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        if (obs === exp) $display("vec %0d %s ok", n_vec, tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tq2 [6] = '{2, 5, 2, 5, 2, 2};
        logic [NQ-1:0] exp_rdy;

        bus.cfg_port_en = 8'hFF;
        bus.in_vld      = 8'hFF;
        for (int i = 0; i < NQ; i++) bus.in_data[i*DW +: DW] = mk_hdr(i, 16'h0800, 8'h06);

        // Reset state
        tick(); tick();
        chk("rst_in_rdy", bus.in_rdy, 0);
        chk("rst_prs_vld", bus.prs_vld, 0);
        chk_data("rst_prs_data", bus.prs_data, '0);
        chk("rst_tag_vld", bus.tag_vld, 0);
        chk("rst_drop_pulse", bus.drop_pulse, 0);
        chk("rst_drop_cnt", bus.drop_cnt, 0);
        chk("rst_err_orphan", bus.err_orphan, 0);
        bus.in_vld = 8'h00;
        rst = 1'b0;
        tick();

        // 1: all queues valid -> strict rotation, tags 5 cycles after accept
        bus.in_vld = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            #1;
            exp_rdy = 8'(1) << (k % 8);
            chk($sformatf("t1_rdy_%0d", k), bus.in_rdy, exp_rdy);
            if (k >= 1) begin
                chk($sformatf("t1_prs_vld_%0d", k), bus.prs_vld, 1);
                chk_data($sformatf("t1_prs_data_%0d", k), bus.prs_data, mk_hdr((k - 1) % 8, 16'h0800, 8'h06));
            end
            if (k >= 5) begin
                chk($sformatf("t1_tag_vld_%0d", k), bus.tag_vld, 1);
                chk($sformatf("t1_tag_qid_%0d", k), bus.tag_qid, (k - 5) % 8);
            end else begin
                chk($sformatf("t1_tag_vld_%0d", k), bus.tag_vld, 0);
            end
            tick();
        end
        bus.in_vld = 8'h00;
        repeat (6) tick();
        chk("t1_drain_tag_vld", bus.tag_vld, 0);
        chk("t1_drop_cnt", bus.drop_cnt, 0);
        chk("t1_err_orphan", bus.err_orphan, 0);

        // 2: ptr to 3 via queue 2, then queues 2/5 alternate; disabling 5 leaves only 2
        bus.in_vld = 8'h04; #1; chk("t2_rdy_setup", bus.in_rdy, 8'h04); tick();
        bus.in_vld = 8'h24; #1; chk("t2_rdy_c1", bus.in_rdy, 8'h20); tick();
        #1; chk("t2_rdy_c2", bus.in_rdy, 8'h04); tick();
        #1; chk("t2_rdy_c3", bus.in_rdy, 8'h20); tick();
        bus.cfg_port_en = 8'hDF;
        #1; chk("t2_rdy_dis_c4", bus.in_rdy, 8'h04); tick();
        #1; chk("t2_rdy_dis_c5", bus.in_rdy, 8'h04);
        chk("t2_tag_qid_c5", bus.tag_qid, tq2[0]); tick();
        bus.in_vld = 8'h20;
        #1; chk("t2_rdy_disabled_only", bus.in_rdy, 8'h00);
        chk("t2_tag_qid_c6", bus.tag_qid, tq2[1]); tick();
        bus.in_vld = 8'h00;
        bus.cfg_port_en = 8'hFF;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t2_tag_vld_%0d", j), bus.tag_vld, 1);
            chk($sformatf("t2_tag_qid_%0d", j), bus.tag_qid, tq2[2 + j]);
            tick();
        end
        chk("t2_tag_vld_end", bus.tag_vld, 0);

        // 3: ARP header from queue 1 is dropped at accept+5
        bus.in_data[1*DW +: DW] = mk_hdr(1, 16'h0806, 8'h06);
        bus.in_vld = 8'h02;
        #1; chk("t3_rdy", bus.in_rdy, 8'h02);
        chk("t3_cnt_before", bus.drop_cnt, 0);
        tick();
        bus.in_vld = 8'h00;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("t3_no_drop_%0d", j), bus.drop_pulse, 0);
            chk($sformatf("t3_prs_vld_out_%0d", j), bus.prs_vld_out, 0);
            tick();
        end
        chk("t3_drop_pulse", bus.drop_pulse, 1);
        chk("t3_drop_qid", bus.drop_qid, 1);
        chk("t3_drop_cnt", bus.drop_cnt, 1);
        chk("t3_tag_vld", bus.tag_vld, 0);
        tick();
        chk("t3_pulse_end", bus.drop_pulse, 0);
        chk("t3_cnt_hold", bus.drop_cnt, 1);

        // 4: four more drops back to back; 2-bit twin saturates at 3
        bus.in_vld = 8'h02;
        for (int j = 0; j < 4; j++) begin
            #1; chk($sformatf("t4_rdy_%0d", j), bus.in_rdy, 8'h02); tick();
        end
        bus.in_vld = 8'h00;
        tick();
        chk("t4_pulse_b5", bus.drop_pulse, 1);
        chk("t4_cnt_b5", bus.drop_cnt, 2);
        chk("t4_scnt_b5", bus_s.drop_cnt, 2);
        tick();
        chk("t4_cnt_b6", bus.drop_cnt, 3);
        chk("t4_scnt_b6", bus_s.drop_cnt, 3);
        tick();
        chk("t4_cnt_b7", bus.drop_cnt, 4);
        chk("t4_scnt_sat_b7", bus_s.drop_cnt, 3);
        tick();
        chk("t4_cnt_b8", bus.drop_cnt, 5);
        chk("t4_scnt_sat_b8", bus_s.drop_cnt, 3);
        tick();
        chk("t4_pulse_end", bus.drop_pulse, 0);
        chk("t4_scnt_final", bus_s.drop_cnt, 3);

        // 5: parser valid with empty tag pipe -> sticky orphan error
        chk("t5_orphan_before", bus.err_orphan, 0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("t5_orphan_set", bus.err_orphan, 1);
        chk("t5_tag_vld", bus.tag_vld, 0);
        chk("t5_no_drop", bus.drop_pulse, 0);
        repeat (3) tick();
        chk("t5_orphan_sticky", bus.err_orphan, 1);

        // 6: reset with three tags in flight
        bus.in_data[1*DW +: DW] = mk_hdr(1, 16'h0800, 8'h06);
        bus.in_vld = 8'h70;
        #1; chk("t6_rdy_q4", bus.in_rdy, 8'h10); tick();
        #1; chk("t6_rdy_q5", bus.in_rdy, 8'h20); tick();
        #1; chk("t6_rdy_q6", bus.in_rdy, 8'h40); tick();
        bus.in_vld = 8'h00;
        tick();
        bus.in_vld = 8'hFF;
        rst = 1'b1;
        #1;
        chk("t6_rst_rdy", bus.in_rdy, 0);
        chk("t6_rst_prs_vld", bus.prs_vld, 0);
        chk_data("t6_rst_prs_data", bus.prs_data, '0);
        chk("t6_rst_tag_vld", bus.tag_vld, 0);
        chk("t6_rst_err_orphan", bus.err_orphan, 0);
        chk("t6_rst_drop_cnt", bus.drop_cnt, 0);
        chk("t6_rst_scnt", bus_s.drop_cnt, 0);
        chk("t6_rst_drop_qid", bus.drop_qid, 0);
        tick(); tick();
        bus.in_vld = 8'h00;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t6_post_drop_%0d", j), bus.drop_pulse, 0);
            chk($sformatf("t6_post_tag_%0d", j), bus.tag_vld, 0);
            tick();
        end
        chk("t6_post_cnt", bus.drop_cnt, 0);
        chk("t6_post_orphan", bus.err_orphan, 0);
        bus.in_vld = 8'hFF;
        #1; chk("t6_first_grant", bus.in_rdy, 8'h01);
        tick();
        bus.in_vld = 8'h00;
        chk("t6_first_prs_vld", bus.prs_vld, 1);
        chk_data("t6_first_prs_data", bus.prs_data, mk_hdr(0, 16'h0800, 8'h06));
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
